// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Scans one digit per slot with leading anode dead-time and frame-aligned double buffering.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]     act_blank_q, act_blank_d;
  logic [4*NUM_DIGITS-1:0]   pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      frame_start_q, frame_start_d;

  logic                      slot_wrap;
  logic                      frame_edge;
  logic                      all_zero;
  logic [NUM_DIGITS-1:0]     blank_vec;
  logic [3:0]                cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_wrap  = (cnt_q == CNT_MAX);
    frame_edge = slot_wrap && (idx_q == IDX_MAX);
    cnt_d      = slot_wrap ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    // Registered from next-state so the pulse coincides with the boundary cycle itself.
    frame_start_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);

    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    if (frame_edge && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end
    // A coincident load must stay pending, so it is applied after the swap.
    if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (act_data_q[4*k +: 4] == 4'h0);
      blank_vec[k] = act_blank_q[k] | (lz_en && (k > 0) && all_zero);
    end
    cur_nib = act_data_q[4*idx_q +: 4];

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((cnt_q >= DEAD) && !blank_vec[idx_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex7(cur_nib);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based reference model queues expected pin
// values every clock and a negedge monitor compares them against the DUT.
module tb_seg_scan_ctrl;

  localparam int N    = 4;
  localparam int RD   = 8;
  localparam int DEAD = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   blank_in = '0;
  logic           lz_en = 1'b0;
  logic           load = 1'b0;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_start;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: t is the number of clocks since reset released.
  int             t = 0;
  logic [4*N-1:0] m_act_data = '0, m_pend_data = '0;
  logic [N-1:0]   m_act_dp = '0, m_pend_dp = '0;
  logic [N-1:0]   m_act_blank = '0, m_pend_blank = '0;
  bit             m_pend_valid = 1'b0;
  logic [12:0]    exp_q [$];
  int             vectors = 0;
  int             miscompares = 0;

  always @(posedge clk) begin
    int          slot, digit;
    bit          dark;
    logic [12:0] e;
    if (rst) begin
      t = 0;
      m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
      m_pend_valid = 1'b0;
      e = {4'b1111, 7'h7F, 1'b1, 1'b0};
    end else begin
      slot  = t % RD;
      digit = (t / RD) % N;
      dark  = (slot < DEAD) || m_act_blank[digit] ||
              (lz_en && digit > 0 && (m_act_data >> (4 * digit)) == 0);
      if (dark)
        e = {4'b1111, 7'h7F, 1'b1, 1'b0};
      else
        e = {~(4'b0001 << digit), hex_tab[(m_act_data >> (4 * digit)) & 16'hF],
             ~m_act_dp[digit], 1'b0};
      e[0] = (((t + 1) % RD) == RD - 1) && ((((t + 1) / RD) % N) == N - 1);
      if (slot == RD - 1 && digit == N - 1 && m_pend_valid) begin
        m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
        m_pend_valid = 1'b0;
      end
      if (load) begin
        m_pend_data = data_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
        m_pend_valid = 1'b1;
      end
      t++;
    end
    exp_q.push_back(e);
  end

  task automatic checkOutput(input logic [12:0] e);
    vectors++;
    if ({an, seg, dp, frame_start} !== e) begin
      miscompares++;
      $display("[TB] FAIL scan_pins t=%0d got an=%b seg=%b dp=%b fs=%b required an=%b seg=%b dp=%b fs=%b",
               t, an, seg, dp, frame_start, e[12:9], e[8:2], e[1], e[0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic [4*N-1:0] d, input logic [N-1:0] p,
                               input logic [N-1:0] b);
    data_in = d; dp_in = p; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * RD * N && (t % (RD * N)) != ph; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    repeat (80) @(negedge clk);

    lz_en = 1'b1;
    applyStimulus(16'h0050, 4'b0000, 4'b0000);
    repeat (70) @(negedge clk);
    applyStimulus(16'h0000, 4'b0000, 4'b0000);
    repeat (70) @(negedge clk);
    lz_en = 1'b0;

    applyStimulus(16'h9876, 4'b0100, 4'b0001);
    repeat (70) @(negedge clk);

    wait_phase(20);
    applyStimulus(16'h1111, 4'b0000, 4'b0000);
    wait_phase(RD * N - 1);
    applyStimulus(16'hABCD, 4'b0000, 4'b0000);
    repeat (100) @(negedge clk);

    wait_phase(10);
    applyStimulus(16'h7777, 4'b1111, 4'b0000);
    wait_phase(2 * RD + 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      load     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      rst      = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
